// File: rtl/swdb_pkg.sv
// Shared types and default constants for the switch debouncer.
// Optional feature macro: SWDB_IRQ_EN (change-pending interrupt).
package swdb_pkg;

  typedef enum logic {
    SWDB_STABLE,
    SWDB_PENDING
  } swdb_state_t;

  localparam int SWDB_WIDTH         = 8;
  localparam int SWDB_SYNC_STAGES   = 2;
  localparam int SWDB_STABLE_CYCLES = 1_000_000;
  localparam logic [7:0] SWDB_RESET_VAL = 8'h00;

endpackage

// File: rtl/swdb_bit.sv
// One switch bit: synchroniser, stability FSM/counter, edge pulses.
// Optional feature macro: SWDB_IRQ_EN (handled in the top only).
module swdb_bit
  import swdb_pkg::*;
#(
  parameter int   SYNC_STAGES   = SWDB_SYNC_STAGES,
  parameter int   STABLE_CYCLES = SWDB_STABLE_CYCLES,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  swdb_state_t            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state: shift synchroniser, track how long s has differed
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      SWDB_STABLE: begin
        cnt_d = '0;
        if (s != deb_q) begin
          if (CNT_LAST == '0) begin
            deb_d  = s;
            rise_d = s;
            fall_d = ~s;
          end else begin
            state_d = SWDB_PENDING;
            cnt_d   = CW'(1);
          end
        end
      end
      SWDB_PENDING: begin
        if (s == deb_q) begin
          state_d = SWDB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SWDB_STABLE;
          cnt_d   = '0;
          deb_d   = s;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = SWDB_STABLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_BIT}};
      state_q <= SWDB_STABLE;
      cnt_q   <= '0;
      deb_q   <= RESET_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign deb  = deb_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/switch_debounce_sync.sv
// Debounced, synchronised slide-switch bus for the switches PIO.
// Optional feature macro: SWDB_IRQ_EN (change-pending irq, set wins).
module switch_debounce_sync
  import swdb_pkg::*;
#(
  parameter int WIDTH         = SWDB_WIDTH,
  parameter int SYNC_STAGES   = SWDB_SYNC_STAGES,
  parameter int STABLE_CYCLES = SWDB_STABLE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(SWDB_RESET_VAL)
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switches_export,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             irq,
  input  logic             irq_clr
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    swdb_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_BIT    (RESET_VAL[i])
    ) u_bit (
      .clk (clk_clk),
      .rst (reset_reset),
      .raw (sw_raw[i]),
      .deb (switches_export[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i])
    );
  end

`ifdef SWDB_IRQ_EN
  logic irq_q, irq_d;

  // Pending flag: any debounced edge sets it, set beats clear
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if ((|sw_rise) | (|sw_fall)) irq_d = 1'b1;
  end

  // Pending flag register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) irq_q <= 1'b0;
    else             irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Scoreboard bench for switch_debounce_sync (W=8, 2 sync, 4 stable).
// Honours SWDB_IRQ_EN for the expected irq values.
module tb_switch_debounce_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw;
  logic [7:0] sw_exp, rise, fall;
  logic       irq, irq_clr;

  int cyc = 0;
  int n_asrt = 0;
  int n_fail = 0;

`ifdef SWDB_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  typedef struct {
    int         due;
    string      tag;
    logic [7:0] e_exp;
    logic [7:0] e_rise;
    logic [7:0] e_fall;
    bit         ci;
    logic       e_irq;
  } exp_t;

  exp_t sb[$];

  switch_debounce_sync #(
    .WIDTH        (8),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .RESET_VAL    (8'h00)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .sw_raw         (raw),
    .switches_export(sw_exp),
    .sw_rise        (rise),
    .sw_fall        (fall),
    .irq            (irq),
    .irq_clr        (irq_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(int d, string tag, logic [7:0] e, logic [7:0] r,
                      logic [7:0] f, bit ci = 0, logic ei = 1'b0);
    exp_t x;
    int k;
    x = '{due: d, tag: tag, e_exp: e, e_rise: r, e_fall: f,
          ci: ci, e_irq: ei};
    k = 0;
    while (k < sb.size() && sb[k].due <= d) k++;
    sb.insert(k, x);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every entry that falls due this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      if (x.due < cyc) begin
        check({x.tag, "_missed"}, cyc, x.due);
      end else begin
        check({x.tag, "_lvl"}, sw_exp, x.e_exp);
        check({x.tag, "_rise"}, rise, x.e_rise);
        check({x.tag, "_fall"}, fall, x.e_fall);
        if (x.ci) check({x.tag, "_irq"}, irq, x.e_irq);
      end
    end
  end

  // Move to a new stable level and verify it lands 6 cycles later
  task automatic settle(logic [7:0] from, logic [7:0] to);
    raw = to;
    push(cyc + 6, "settle", to, to & ~from, from & ~to);
    step(8);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    raw = 8'hFF;
    irq_clr = 1'b0;
    step(1);

    // 1: reset holds 00 despite FF, then FF after 6 cycles
    c = cyc;
    for (int i = 1; i <= 3; i++)
      push(c + i, "t1_rst", 8'h00, 8'h00, 8'h00, 1, 1'b0);
    step(3);
    rst = 1'b0;
    c = cyc;
    for (int i = 1; i <= 5; i++)
      push(c + i, "t1_wait", 8'h00, 8'h00, 8'h00);
    push(c + 6, "t1_up", 8'hFF, 8'hFF, 8'h00);
    push(c + 7, "t1_hold", 8'hFF, 8'h00, 8'h00);
    step(8);

    // 2: 3-cycle glitch on bit0 is rejected
    settle(8'hFF, 8'h00);
    c = cyc;
    raw = 8'h01;
    for (int i = 1; i <= 10; i++)
      push(c + i, "t2_glitch", 8'h00, 8'h00, 8'h00);
    step(3);
    raw = 8'h00;
    step(8);

    // 3: A5 -> 25 gives a single fall on bit7
    settle(8'h00, 8'hA5);
    c = cyc;
    raw = 8'h25;
    for (int i = 1; i <= 5; i++)
      push(c + i, "t3_wait", 8'hA5, 8'h00, 8'h00);
    push(c + 6, "t3_fall", 8'h25, 8'h00, 8'h80);
    push(c + 7, "t3_hold", 8'h25, 8'h00, 8'h00);
    step(8);

    // 4: staggered bits update independently
    settle(8'h25, 8'h00);
    c = cyc;
    raw = 8'h08;
    push(c + 5, "t4_pre", 8'h00, 8'h00, 8'h00);
    push(c + 6, "t4_b3", 8'h08, 8'h08, 8'h00);
    push(c + 7, "t4_b3h", 8'h08, 8'h00, 8'h00);
    push(c + 8, "t4_b5", 8'h28, 8'h20, 8'h00);
    push(c + 9, "t4_b5h", 8'h28, 8'h00, 8'h00);
    step(2);
    raw = 8'h28;
    step(9);

    // 5: reset mid-count discards progress on bit1
    settle(8'h28, 8'h00);
    c = cyc;
    raw = 8'h02;
    for (int i = 1; i <= 4; i++)
      push(c + i, "t5_rst", 8'h00, 8'h00, 8'h00);
    step(2);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    c = cyc;
    for (int i = 1; i <= 5; i++)
      push(c + i, "t5_wait", 8'h00, 8'h00, 8'h00);
    push(c + 6, "t5_up", 8'h02, 8'h02, 8'h00);
    step(8);

    // 6: irq set beats same-cycle clear, next clear drops it
    irq_clr = 1'b1;
    c = cyc;
    push(c + 1, "t6_clr0", 8'h02, 8'h00, 8'h00, 1, 1'b0);
    step(1);
    irq_clr = 1'b0;
    step(1);
    c = cyc;
    raw = 8'h00;
    push(c + 6, "t6_pulse", 8'h00, 8'h00, 8'h02, 1, 1'b0);
    push(c + 7, "t6_set", 8'h00, 8'h00, 8'h00, 1, IRQ_ON);
    push(c + 8, "t6_clr", 8'h00, 8'h00, 8'h00, 1, 1'b0);
    step(6);
    irq_clr = 1'b1;
    step(2);
    irq_clr = 1'b0;
    step(2);

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    check("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
